// File: rtl/cnn_infer_mc_if.sv
// Handshake bundle of the CNN inference block: pixel stream, weight writes and results.
interface cnn_infer_mc_if #(
    parameter int WADDR_W = 9,
    parameter int NCLS    = 4
);
    logic                    frame_start;
    logic [7:0]              pixel_in;
    logic                    pixel_valid;
    logic                    pixel_ready;
    logic                    wr_en;
    logic [WADDR_W-1:0]      wr_addr;
    logic [7:0]              wr_data;
    logic                    wr_err;
    logic                    busy;
    logic                    result_valid;
    logic [$clog2(NCLS)-1:0] class_id;
    logic [7:0]              confidence;

    modport master (output frame_start, pixel_in, pixel_valid, wr_en, wr_addr, wr_data,
                    input  pixel_ready, wr_err, busy, result_valid, class_id, confidence);
    modport slave  (input  frame_start, pixel_in, pixel_valid, wr_en, wr_addr, wr_data,
                    output pixel_ready, wr_err, busy, result_valid, class_id, confidence);
endinterface

// File: rtl/cnn_infer_mc.sv
// Single-channel-at-a-time CNN classifier: conv pass per channel, ReLU features,
// dense layer, argmax. One shared 3-stage MAC pipeline serves both layers.
module cnn_infer_mc #(
    parameter int IMG_SIZE   = 1024,
    parameter int KLEN       = 72,
    parameter int NCH        = 4,
    parameter int NCLS       = 4,
    parameter int FEAT_SHIFT = 8,
    parameter int CONF_SHIFT = 0,
    parameter int WADDR_W    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    cnn_infer_mc_if.slave bus
);
    localparam int CB = NCH * KLEN;
    localparam int DW = CB + NCH;
    localparam int DB = DW + NCLS * NCH;
    localparam int WD = DB + NCLS;
    localparam int CW = $clog2(IMG_SIZE + 1);
    localparam int IW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam int KW = (KLEN > 1) ? $clog2(KLEN) : 1;
    localparam int HW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW = $clog2(NCLS);

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_CONV_DRAIN, S_DENSE, S_DENSE_DRAIN, S_DONE
    } state_t;

    logic signed [7:0]  wmem_q [WD];
    logic        [7:0]  pbuf_q [IMG_SIZE];
    logic        [15:0] feat_q [NCH];
    logic signed [31:0] logit_q [NCLS];

    state_t             state_q;
    logic [CW-1:0]      count_q;
    logic               busy_q, inferred_q, result_valid_q, wr_err_q;
    logic [LW-1:0]      class_id_q, cls_q, best_idx_d;
    logic [7:0]         confidence_q, conf_d;
    logic [IW-1:0]      i_q;
    logic [KW-1:0]      k_q;
    logic [HW-1:0]      ch_q;
    logic               v1_q, v2_q;
    logic signed [16:0] op_a_q, op_a_d;
    logic signed [7:0]  op_b_q;
    logic signed [31:0] prod_q, prod_d, acc_q, bias_s, fsh_s, best_s, csh_s;
    logic [15:0]        feat_d;
    logic [WADDR_W-1:0] waddr_s, bias_addr_s;
    logic               wr_ok_s, pixel_ready_s, pix_acc_s, issue_s, drain_done_s;

    assign wr_ok_s       = bus.wr_en && !busy_q && (int'(bus.wr_addr) < WD);
    assign pixel_ready_s = !busy_q && (count_q < CW'(IMG_SIZE));
    assign pix_acc_s     = bus.pixel_valid && pixel_ready_s && !bus.frame_start;
    assign issue_s       = (state_q == S_CONV) || (state_q == S_DENSE);
    assign drain_done_s  = !v1_q && !v2_q;
    assign prod_d        = 32'(op_a_q) * 32'(op_b_q);
    assign bias_s        = 32'(wmem_q[bias_addr_s]);

    // Issue-stage operand select: centred pixel x conv tap, or feature x dense weight.
    always_comb begin
        if (state_q == S_CONV) begin
            waddr_s = WADDR_W'(int'(ch_q) * KLEN + int'(k_q));
            op_a_d  = 17'(signed'({1'b0, pbuf_q[i_q]})) - 17'sd128;
        end else begin
            waddr_s = WADDR_W'(DW + int'(cls_q) * NCH + int'(ch_q));
            op_a_d  = signed'({1'b0, feat_q[ch_q]});
        end
    end

    // Bias that seeds the accumulator for the pass that starts next.
    always_comb begin
        case (state_q)
            S_CONV_DRAIN:  bias_addr_s = (ch_q == HW'(NCH - 1)) ? WADDR_W'(DB)
                                                                : WADDR_W'(CB + int'(ch_q) + 1);
            S_DENSE_DRAIN: bias_addr_s = (cls_q == LW'(NCLS - 1)) ? WADDR_W'(DB)
                                                                  : WADDR_W'(DB + int'(cls_q) + 1);
            default:       bias_addr_s = WADDR_W'(CB);
        endcase
    end

    // ReLU feature with upper saturation, then argmax (first index wins ties) and confidence.
    always_comb begin
        fsh_s = acc_q >>> FEAT_SHIFT;
        if (fsh_s < 32'sd0)          feat_d = 16'd0;
        else if (fsh_s > 32'sd32767) feat_d = 16'd32767;
        else                         feat_d = fsh_s[15:0];
        best_s     = logit_q[0];
        best_idx_d = LW'(0);
        for (int j = 1; j < NCLS; j++) begin
            best_idx_d = (logit_q[j] > best_s) ? LW'(j) : best_idx_d;
            best_s     = (logit_q[j] > best_s) ? logit_q[j] : best_s;
        end
        csh_s = best_s >>> CONF_SHIFT;
        if (best_s < 32'sd0)       conf_d = 8'd0;
        else if (csh_s > 32'sd255) conf_d = 8'd255;
        else                       conf_d = csh_s[7:0];
    end

    // Storage arrays: never reset, written only via guarded strobes.
    always_ff @(posedge clk) begin
        if (wr_ok_s) wmem_q[bus.wr_addr] <= bus.wr_data;
        if (pix_acc_s) pbuf_q[count_q[IW-1:0]] <= bus.pixel_in;
        if (state_q == S_CONV_DRAIN && drain_done_s) feat_q[ch_q] <= feat_d;
        if (state_q == S_DENSE_DRAIN && drain_done_s) logit_q[cls_q] <= acc_q;
    end

    // Control FSM, MAC pipeline and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;         count_q <= CW'(0);
            busy_q <= 1'b0;            inferred_q <= 1'b0;
            result_valid_q <= 1'b0;    wr_err_q <= 1'b0;
            class_id_q <= LW'(0);      confidence_q <= 8'd0;
            i_q <= IW'(0);             k_q <= KW'(0);
            ch_q <= HW'(0);            cls_q <= LW'(0);
            v1_q <= 1'b0;              v2_q <= 1'b0;
            op_a_q <= 17'sd0;          op_b_q <= 8'sd0;
            prod_q <= 32'sd0;          acc_q <= 32'sd0;
        end else begin
            wr_err_q       <= bus.wr_en && !wr_ok_s;
            result_valid_q <= 1'b0;
            v1_q           <= issue_s;
            v2_q           <= v1_q;
            if (issue_s) begin
                op_a_q <= op_a_d;
                op_b_q <= wmem_q[waddr_s];
            end
            if (v1_q) prod_q <= prod_d;
            if (v2_q) acc_q <= acc_q + prod_q;
            if (pix_acc_s) count_q <= count_q + CW'(1);
            if (bus.frame_start) begin
                count_q    <= CW'(0);
                inferred_q <= 1'b0;
                if (busy_q) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    v1_q    <= 1'b0;
                    v2_q    <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_IDLE: if (count_q == CW'(IMG_SIZE) && !inferred_q) begin
                        state_q <= S_CONV;  busy_q <= 1'b1;  inferred_q <= 1'b1;
                        ch_q <= HW'(0);     i_q <= IW'(0);   k_q <= KW'(0);
                        acc_q <= bias_s;
                    end
                    S_CONV: begin
                        i_q <= i_q + IW'(1);
                        k_q <= (k_q == KW'(KLEN - 1)) ? KW'(0) : k_q + KW'(1);
                        if (i_q == IW'(IMG_SIZE - 1)) state_q <= S_CONV_DRAIN;
                    end
                    S_CONV_DRAIN: if (drain_done_s) begin
                        i_q   <= IW'(0);
                        k_q   <= KW'(0);
                        acc_q <= bias_s;
                        if (ch_q == HW'(NCH - 1)) begin
                            state_q <= S_DENSE;  ch_q <= HW'(0);  cls_q <= LW'(0);
                        end else begin
                            state_q <= S_CONV;   ch_q <= ch_q + HW'(1);
                        end
                    end
                    S_DENSE: begin
                        ch_q <= ch_q + HW'(1);
                        if (ch_q == HW'(NCH - 1)) state_q <= S_DENSE_DRAIN;
                    end
                    S_DENSE_DRAIN: if (drain_done_s) begin
                        ch_q  <= HW'(0);
                        acc_q <= bias_s;
                        if (cls_q == LW'(NCLS - 1)) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_DENSE;  cls_q <= cls_q + LW'(1);
                        end
                    end
                    S_DONE: begin
                        class_id_q     <= best_idx_d;
                        confidence_q   <= conf_d;
                        result_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.pixel_ready  = pixel_ready_s;
    assign bus.wr_err       = wr_err_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.class_id     = class_id_q;
    assign bus.confidence   = confidence_q;
endmodule

// File: doc/cnn_infer_mc.md
CNN_INFER_MC -- requirements
Module: cnn_infer_mc

Interface
REQ-001 Parameter IMG_SIZE, default 1024: pixels per frame.
REQ-002 Parameter KLEN, default 72: conv weights per channel, applied cyclically over pixel index.
REQ-003 Parameter NCH, default 4: feature channels.
REQ-004 Parameter NCLS, default 4: output classes.
REQ-005 Parameter FEAT_SHIFT, default 8; CONF_SHIFT, default 0: right-shift amounts for features and confidence.
REQ-006 Parameter WADDR_W, default 9: weight address width; weight RAM depth WD = NCH*KLEN + NCH + NCLS*NCH + NCLS (default 312).
REQ-007 clk  input  1  clock; all logic rising-edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 frame_start  input  1  start new frame; clears pixel count.
REQ-010 pixel_in  input  8  unsigned pixel.
REQ-011 pixel_valid  input  1  pixel_in valid.
REQ-012 pixel_ready  output  1  block accepts a pixel this cycle.
REQ-013 wr_en  input  1  weight write strobe.
REQ-014 wr_addr  input  WADDR_W  weight address.
REQ-015 wr_data  input  8  signed weight/bias.
REQ-016 wr_err  output  1  one-cycle pulse: write dropped.
REQ-017 busy  output  1  inference in progress.
REQ-018 result_valid  output  1  one-cycle pulse: class_id and confidence updated.
REQ-019 class_id  output  $clog2(NCLS)  winning class.
REQ-020 confidence  output  8  saturated confidence.

Function
REQ-021 Weight map: conv w[c][k] at c*KLEN+k; conv bias[c] at NCH*KLEN+c; dense w[j][c] at NCH*KLEN+NCH+j*NCH+c; dense bias[j] after that.
REQ-022 Write accepted when wr_en, !busy, and wr_addr<WD; otherwise dropped, wr_err high next cycle.
REQ-023 Handshake: pixel accepted when pixel_valid && pixel_ready; pixel_ready = !busy && count<IMG_SIZE.
REQ-024 Accepted pixels stored at count, then count increments; frame_start has priority over a same-cycle pixel, which is not stored.
REQ-025 FSM states: IDLE, CONV, CONV_DRAIN, DENSE, DENSE_DRAIN, DONE.
REQ-026 IDLE->CONV when count==IMG_SIZE and frame not yet inferred; busy set.
REQ-027 CONV: channel c passes over i=0..IMG_SIZE-1; acc starts at bias[c] sign-extended; acc += (pixel[i]-128)*w[c][i mod KLEN]; modulo uses a wrapping index counter, no divider.
REQ-028 MAC pipeline: address/fetch, operand register, product register, accumulate; one MAC issued per cycle.
REQ-029 CONV_DRAIN: after pipeline empties, feature[c] = max(0, acc>>>FEAT_SHIFT) saturated to 32767; next channel or DENSE after c=NCH-1.
REQ-030 DENSE/DENSE_DRAIN: logit[j] = dense bias[j] + sum over c of feature[c]*w[j][c]; same pipeline.
REQ-031 Accumulator 32-bit signed; ACC wrap not permitted for default parameters.
REQ-032 DONE: class_id = argmax logit, lowest index on tie; confidence = 0 if top logit<0, else min(255, logit>>CONF_SHIFT); result_valid pulses; busy clears; -> IDLE.
REQ-033 Latency: result_valid no later than NCH*(IMG_SIZE+4)+NCLS*(NCH+4)+4 cycles after final pixel accepted.
REQ-034 frame_start while busy aborts: -> IDLE, busy low next cycle, no result_valid, count=0.
REQ-035 New frame may load only after busy low; outputs hold until next result_valid.

Reset
REQ-036 On rst_n low: state IDLE, count 0, pixel_ready 1, busy 0, result_valid 0, wr_err 0, class_id 0, confidence 0, pipeline valids 0.
REQ-037 Weight RAM and pixel buffer are not reset; reset mid-inference discards it with no result.

Verification
REQ-038 All weights 0, dense bias[2]=5 -> class_id=2, confidence=5, result_valid single pulse.
REQ-039 conv w[0][*]=1, all pixels 129, dense w[1][0]=10, rest 0 -> feature0=4, class_id=1, confidence=40.
REQ-040 Pixels 255, all conv w=127, dense w[0][*]=127 -> features saturate 32767, class_id=0, confidence=255.
REQ-041 Write at addr 312 and write while busy -> wr_err pulse each, RAM unchanged.
REQ-042 frame_start at CONV cycle 500 -> busy drops, no result_valid; next full frame yields correct result.
REQ-043 pixel_valid held through busy -> pixel_ready 0, no pixels accepted, count stays IMG_SIZE.
